// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
// Request/acknowledge bus between the memory-stage access controller and a
// variable-latency data memory.
//   mem_req   : request valid (initiator -> memory)
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : 64-bit word address
//   mem_wdata : write data (zero on reads)
//   mem_ack   : memory accepted/completed the request (memory -> initiator)
//   mem_rdata : read data, valid while mem_ack is high on a read
// Modports: master (controller side), slave (memory side).
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Initiator side of the Y86-64 data-memory interface. Decodes the memory-stage
// instruction fields, issues at most one read or write over a req/ack bus,
// and reports valM / dmem_error with a one-cycle done pulse. busy stalls the
// stage while the controller is not idle.
//
// Parameters:
//   ADDR_LIMIT : number of 64-bit words; valid word addresses 0..ADDR_LIMIT-1
//   TIMEOUT    : REQ cycles without ack before abort (MEM_TIMEOUT_EN only)
// Optional feature macro: MEM_TIMEOUT_EN (request timeout counter).
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : instruction valid, sampled only in IDLE
//   icode             : instruction code
//   valA, valE, valP  : register A value, ALU result, next PC
//   busy              : high whenever not IDLE
//   done              : one-cycle completion pulse
//   valM, dmem_error  : result and error flag, held until the next done
//   mem               : request/ack bus toward the data memory (master)
module mem_access_ctrl #(
  parameter int ADDR_LIMIT = 1024,
  parameter int TIMEOUT    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [3:0]               icode,
  input  logic [63:0]              valA,
  input  logic [63:0]              valE,
  input  logic [63:0]              valP,
  output logic                     busy,
  output logic                     done,
  output logic [63:0]              valM,
  output logic                     dmem_error,
  mem_access_ctrl_if.master        mem
);

  localparam logic [63:0] LIMIT   = 64'(ADDR_LIMIT);
  localparam logic [63:0] NO_DATA = 64'hF;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_reg, state_next;
  logic        we_reg, we_next;
  logic [63:0] addr_reg, addr_next;
  logic [63:0] wdata_reg, wdata_next;
  logic [63:0] valm_reg, valm_next;
  logic        err_reg, err_next;

  // Instruction decode: which access (if any), its address and write data.
  logic        dec_access;
  logic        dec_we;
  logic [63:0] dec_addr;
  logic [63:0] dec_wdata;

  always_comb begin
    dec_access = 1'b1;
    dec_we     = 1'b0;
    dec_addr   = valE;
    dec_wdata  = '0;
    case (icode)
      4'h4, 4'hA: begin            // rmmovq / pushq: store valA at valE
        dec_we    = 1'b1;
        dec_wdata = valA;
      end
      4'h8: begin                  // call: push return address
        dec_we    = 1'b1;
        dec_wdata = valP;
      end
      4'h5: ;                      // mrmovq: load from valE
      4'h9, 4'hB: dec_addr = valA; // ret / popq: load from old stack pointer
      default: begin
        dec_access = 1'b0;
        dec_addr   = '0;
      end
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          expired;

  // The count would reach TIMEOUT on this edge if ack is still low.
  assign expired = (cnt_reg == CW'(TIMEOUT - 1));
`endif

  always_comb begin
    state_next = state_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    valm_next  = valm_reg;
    err_next   = err_reg;
`ifdef MEM_TIMEOUT_EN
    cnt_next   = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (!dec_access) begin
            valm_next  = NO_DATA;
            err_next   = 1'b0;
            state_next = DONE;
          end else if (dec_addr >= LIMIT) begin
            // Out-of-range: report without ever touching the bus.
            valm_next  = NO_DATA;
            err_next   = 1'b1;
            state_next = DONE;
          end else begin
            we_next    = dec_we;
            addr_next  = dec_addr;
            wdata_next = dec_wdata;
            state_next = REQ;
`ifdef MEM_TIMEOUT_EN
            cnt_next   = '0;
`endif
          end
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          valm_next  = we_reg ? NO_DATA : mem.mem_rdata;
          err_next   = 1'b0;
          state_next = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else begin
          cnt_next = cnt_reg + 1'b1;
          if (expired) begin
            valm_next  = NO_DATA;
            err_next   = 1'b1;
            state_next = DONE;
          end
        end
`endif
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      valm_reg  <= '0;
      err_reg   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_reg   <= '0;
`endif
    end else begin
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      valm_reg  <= valm_next;
      err_reg   <= err_next;
`ifdef MEM_TIMEOUT_EN
      cnt_reg   <= cnt_next;
`endif
    end
  end

  // mem_req is decoded from the state register only, so it cannot depend
  // combinationally on mem_ack and drops immediately on reset.
  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);
  assign valM          = valm_reg;
  assign dmem_error    = err_reg;
  assign mem.mem_req   = (state_reg == REQ);
  assign mem.mem_we    = we_reg;
  assign mem.mem_addr  = addr_reg;
  assign mem.mem_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Randomized scoreboard bench for mem_access_ctrl. The stimulus task computes
// the expected result of each instruction from a reference memory and the
// instruction table, queues it, and separate monitors compare bus activity and
// done responses against those queues.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  localparam int ADDR_LIMIT = 1024;
  localparam int TMO        = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valA, valE, valP;
  logic        busy, done, dmem_error;
  logic [63:0] valM;

  mem_access_ctrl_if mem();

  mem_access_ctrl #(.ADDR_LIMIT(ADDR_LIMIT), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode),
    .valA(valA), .valE(valE), .valP(valP),
    .busy(busy), .done(done), .valM(valM), .dmem_error(dmem_error),
    .mem(mem)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [63:0] valm; logic err; } resp_t;
  typedef struct { logic we; logic [63:0] addr; logic [63:0] wdata; } bus_t;

  resp_t       exp_q[$];
  bus_t        bus_q[$];
  logic [63:0] ref_mem   [0:ADDR_LIMIT-1];
  logic [63:0] slave_mem [0:ADDR_LIMIT-1];
  int          ack_delay = 0;
  int          txn = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  // Memory model: acks after ack_delay REQ cycles; random ack outside REQ.
  initial begin
    int req_cycles;
    req_cycles = 0;
    mem.mem_ack = 1'b0;
    mem.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem.mem_rdata = {$urandom, $urandom};
      mem.mem_ack   = 1'($urandom_range(0, 1));
      if (!rst && mem.mem_req) begin
        mem.mem_ack = 1'b0;
        if (req_cycles >= ack_delay) begin
          mem.mem_ack = 1'b1;
          if (mem.mem_we) slave_mem[mem.mem_addr[9:0]] = mem.mem_wdata;
          else            mem.mem_rdata = slave_mem[mem.mem_addr[9:0]];
          req_cycles = 0;
        end else begin
          req_cycles++;
        end
      end else begin
        req_cycles = 0;
      end
    end
  end

  // Bus monitor: every cycle of a request must match the queued expectation.
  bit prev_req = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      if (mem.mem_req) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req actual=req addr %h required=no request", mem.mem_addr);
        end else begin
          chk("bus_we",    64'(mem.mem_we), 64'(bus_q[0].we));
          chk("bus_addr",  mem.mem_addr,    bus_q[0].addr);
          chk("bus_wdata", mem.mem_wdata,   bus_q[0].wdata);
        end
      end else if (prev_req && bus_q.size() != 0) begin
        void'(bus_q.pop_front());
      end
      prev_req = mem.mem_req;
    end
  end

  // Response monitor: each done pulse pops one expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=done valM %h required=no done", valM);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("valM",       valM,             e.valm);
        chk("dmem_error", 64'(dmem_error),  64'(e.err));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},  64'(busy),          64'h0);
    chk({tag, "_done"},  64'(done),          64'h0);
    chk({tag, "_valM"},  valM,               64'h0);
    chk({tag, "_err"},   64'(dmem_error),    64'h0);
    chk({tag, "_req"},   64'(mem.mem_req),   64'h0);
    chk({tag, "_we"},    64'(mem.mem_we),    64'h0);
    chk({tag, "_addr"},  mem.mem_addr,       64'h0);
    chk({tag, "_wdata"}, mem.mem_wdata,      64'h0);
  endtask

  // Issue one instruction; d = REQ cycles before the memory acks.
  task automatic run_instr(input logic [3:0] ic, input logic [63:0] a, e, p,
                           input int d, input bit disturb);
    bit          is_rd, is_wr;
    logic [63:0] ad, wd;
    resp_t       r;
    int          lat, busy_cnt, done_cnt, done_at, cyc;
    is_rd = ic inside {4'h5, 4'h9, 4'hB};
    is_wr = ic inside {4'h4, 4'h8, 4'hA};
    ad    = (ic inside {4'h9, 4'hB}) ? a : e;
    wd    = (ic == 4'h8) ? p : a;
    if (!is_rd && !is_wr) begin
      r = '{64'hF, 1'b0}; lat = 1;
    end else if (ad >= 64'(ADDR_LIMIT)) begin
      r = '{64'hF, 1'b1}; lat = 1;
    end else if (TO_EN && d >= TMO) begin
      r = '{64'hF, 1'b1}; lat = TMO + 1;
      bus_q.push_back('{is_wr, ad, is_wr ? wd : 64'h0});
    end else begin
      r.valm = is_wr ? 64'hF : ref_mem[ad[9:0]];
      r.err  = 1'b0;
      lat    = d + 2;
      if (is_wr) ref_mem[ad[9:0]] = wd;
      bus_q.push_back('{is_wr, ad, is_wr ? wd : 64'h0});
    end
    exp_q.push_back(r);
    ack_delay = d;

    @(negedge clk);
    start = 1'b1; icode = ic; valA = a; valE = e; valP = p;
    @(posedge clk); #1;
    start = disturb;
    valA = {$urandom, $urandom}; valE = {$urandom, $urandom}; valP = {$urandom, $urandom};
    cyc = 1; busy_cnt = 0; done_cnt = 0; done_at = 0;
    while (busy && cyc <= 300) begin
      busy_cnt++;
      if (done) begin done_cnt++; done_at = cyc; end
      if (disturb) begin
        icode = 4'($urandom);
        valA = {$urandom, $urandom}; valE = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("latency",     64'(done_at),  64'(lat));
    chk("busy_cycles", 64'(busy_cnt), 64'(lat));
    chk("done_count",  64'(done_cnt), 64'h1);
    $display("txn %0d icode=%h addr=%h delay=%0d disturb=%0d latency=%0d valM=%h err=%0d",
             txn, ic, ad, d, disturb, done_at, valM, dmem_error);
    txn++;
  endtask

  function automatic logic [63:0] pick_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 7)       return 64'($urandom_range(0, 15));
    else if (sel == 7) return {$urandom, $urandom};
    else if (sel == 8) return 64'(ADDR_LIMIT - 1);
    else               return 64'(ADDR_LIMIT);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  codes [0:10];
    logic [63:0] v;
    codes = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'h4, 4'h5, 4'h9, 4'hB, 4'h0};
    for (int i = 0; i < ADDR_LIMIT; i++) begin
      v = {$urandom, $urandom};
      ref_mem[i] = v;
      slave_mem[i] = v;
    end
    rst = 1'b1; start = 1'b0; icode = '0; valA = '0; valE = '0; valP = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Directed cases
    run_instr(4'h4, 64'h55, 64'd3, 64'h0, 2, 1'b0);
    run_instr(4'h5, 64'h0, 64'd3, 64'h0, 0, 1'b0);
    run_instr(4'h8, 64'h0, 64'd7, 64'h20, 1, 1'b0);
    run_instr(4'h9, 64'd7, 64'h0, 64'h0, 0, 1'b0);
    run_instr(4'hB, 64'd7, 64'h0, 64'h0, 3, 1'b0);
    run_instr(4'h6, 64'd1, 64'd2, 64'd3, 0, 1'b0);
    run_instr(4'h5, 64'h0, 64'd1024, 64'h0, 0, 1'b0);
    run_instr(4'h9, 64'd1023, 64'h0, 64'h0, 0, 1'b0);
    run_instr(4'hB, 64'h8000_0000_0000_0000, 64'h0, 64'h0, 0, 1'b0);
    run_instr(4'hA, 64'h1234_5678_9ABC_DEF0, 64'd5, 64'h0, 4, 1'b1);
    run_instr(4'h5, 64'h0, 64'd5, 64'h0, 2, 1'b1);

    // Reset in the middle of a request: no done, all outputs cleared.
    ack_delay = 1000;
    bus_q.push_back('{1'b0, 64'd9, 64'h0});
    @(negedge clk); start = 1'b1; icode = 4'h5; valE = 64'd9;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    bus_q.delete();
    repeat (2) @(negedge clk);
    chk("abort_no_done", 64'(done), 64'h0);
    rst = 1'b0;
    run_instr(4'h5, 64'h0, 64'd3, 64'h0, 1, 1'b0);

`ifdef MEM_TIMEOUT_EN
    run_instr(4'h5, 64'h0, 64'd2, 64'h0, 1000, 1'b0);
    run_instr(4'h4, 64'hAB, 64'd2, 64'h0, TMO - 1, 1'b0);
`endif

    // Randomized instructions
    for (int n = 0; n < 60; n++) begin
      logic [3:0] ic;
      ic = codes[$urandom_range(0, 10)];
      if (ic == 4'h0) ic = 4'($urandom);
      run_instr(ic, pick_addr(), pick_addr(), {$urandom, $urandom},
                $urandom_range(0, 6), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
